// File: rtl/sub_pkg.sv
// Shared constants for the nibble-serial subtractor: FSM encoding and slice width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_pkg;

  // Bits consumed by the shared subtractor slice on each clock.
  localparam int SLICE_W = 4;

  // FSM encoding, kept as plain constants so older code that compares raw
  // state values continues to work.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/sub_seq_ctrl_if.sv
// Operand/result handshake bundle for sub_seq_ctrl.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
// Ports: in_valid/in_ready/A/B/bin (operand side), out_valid/out_ready/D/Bout/zero (result side).
// master = producer+consumer side, slave = the sequencer.
interface sub_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             zero;

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, D, Bout, zero
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, D, Bout, zero
  );
endinterface

// File: rtl/sub_slice4.sv
// Combinational 4-bit borrow-chained subtractor: d = a - b - bi, bo = borrow out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b (4-bit operands), bi (borrow in) -> d (4-bit difference), bo (borrow out).
module sub_slice4
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  // brw[i] is the borrow into bit i; brw[SLICE_W] leaves the slice.
  logic [SLICE_W:0] brw;

  assign brw[0] = bi;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fs
    assign d[i]     = a[i] ^ b[i] ^ brw[i];
    // Borrow when a<b at this bit, or bits equal and a borrow is already pending.
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bo = brw[SLICE_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Nibble-serial WIDTH-bit subtractor D = A - B - bin using one shared 4-bit slice, LSB nibble first.
// Latency: out_valid rises WIDTH/4 clocks after the accepting edge; one result per WIDTH/4+2 clocks max.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; no input->output comb path.
// Ports: clk, rst (async active-high), bus (sub_seq_ctrl_if.slave: operand and result handshakes).
module sub_seq_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,  // multiple of SLICE, at least SLICE
  parameter int SLICE = 4   // must equal SLICE_W (width of sub_slice4)
) (
  input  logic         clk,
  input  logic         rst,
  sub_seq_ctrl_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ar;
  logic [WIDTH-1:0]   br;
  logic [WIDTH-1:0]   dr;
  logic               borrow;
  logic               bout_r;
  logic               zero_r;

  logic [SLICE_W-1:0] s_d;
  logic               s_bo;
  logic [WIDTH-1:0]   dr_nxt;

  // The only arithmetic in the block: always works on the low nibble of the
  // shifting operand registers with the borrow carried from the previous nibble.
  sub_slice4 u_slice (
    .a  (ar[SLICE_W-1:0]),
    .b  (br[SLICE_W-1:0]),
    .bi (borrow),
    .d  (s_d),
    .bo (s_bo)
  );

  // New nibble enters from the MSB side so that after N shifts the LSB nibble
  // computed first has landed in bits [SLICE_W-1:0].
  assign dr_nxt = (dr >> SLICE_W) | (WIDTH'(s_d) << (WIDTH - SLICE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ar     <= '0;
      br     <= '0;
      dr     <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            ar     <= bus.A;
            br     <= bus.B;
            borrow <= bus.bin;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          dr     <= dr_nxt;
          ar     <= ar >> SLICE_W;
          br     <= br >> SLICE_W;
          borrow <= s_bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state  <= S_DONE;
            bout_r <= s_bo;
            zero_r <= (dr_nxt == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.D         = dr;
  assign bus.Bout      = bout_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Bench for sub_seq_ctrl at WIDTH=8 and WIDTH=16 sharing one clock and reset.
// Latency: n/a.
// Backpressure: drives random and held out_ready to exercise result stalls.
module tb_sub_seq_ctrl;

  logic clk;
  logic rst;

  sub_seq_ctrl_if #(.WIDTH(8))  if8 ();
  sub_seq_ctrl_if #(.WIDTH(16)) if16 ();

  sub_seq_ctrl #(.WIDTH(8),  .SLICE(4)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  sub_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one slot per DUT: 0 = 8-bit, 1 = 16-bit)
  // A DUT is either free, or owes exactly one result that must appear N clocks
  // after acceptance and stay until the consumer takes it.
  bit          pend     [2];
  int          elapsed  [2];
  logic [15:0] exp_d    [2];
  bit          exp_bo   [2];
  bit          exp_z    [2];
  bit          stream   [2];
  int          last_acc [2];

  int          m_n;
  logic [15:0] m_mask, m_a, m_b, m_d;
  logic        m_bi, m_iv, m_iy, m_ov, m_or, m_bo, m_z;
  int          m_diff;
  string       m_tag;

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; elapsed[k] = 0; stream[k] = 0; last_acc[k] = -1;
      exp_d[k] = '0; exp_bo[k] = 0; exp_z[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_n    = (k == 1) ? 4 : 2;
      m_mask = (k == 1) ? 16'hFFFF : 16'h00FF;
      m_tag  = (k == 1) ? "w16" : "w8";
      if (k == 1) begin
        m_a = if16.A; m_b = if16.B; m_bi = if16.bin; m_iv = if16.in_valid;
        m_iy = if16.in_ready; m_ov = if16.out_valid; m_or = if16.out_ready;
        m_d = if16.D; m_bo = if16.Bout; m_z = if16.zero;
      end else begin
        m_a = {8'h00, if8.A}; m_b = {8'h00, if8.B}; m_bi = if8.bin; m_iv = if8.in_valid;
        m_iy = if8.in_ready; m_ov = if8.out_valid; m_or = if8.out_ready;
        m_d = {8'h00, if8.D}; m_bo = if8.Bout; m_z = if8.zero;
      end
      if (!stream[k]) last_acc[k] = -1;
      if (rst) begin
        pend[k] = 0;
      end else begin
        if (pend[k] && elapsed[k] < m_n) elapsed[k]++;
        chk({m_tag, " in_ready"},  m_iy, !pend[k]);
        chk({m_tag, " out_valid"}, m_ov, pend[k] && elapsed[k] >= m_n);
        if (pend[k] && elapsed[k] >= m_n) begin
          chk({m_tag, " D"},    m_d,  exp_d[k]);
          chk({m_tag, " Bout"}, m_bo, exp_bo[k]);
          chk({m_tag, " zero"}, m_z,  exp_z[k]);
        end
        if (m_iv && !pend[k]) begin
          m_diff    = int'(m_a) - int'(m_b) - int'(m_bi);
          exp_d[k]  = m_diff[15:0] & m_mask;
          exp_bo[k] = (m_diff < 0);
          exp_z[k]  = (exp_d[k] == 16'h0);
          pend[k]   = 1;
          elapsed[k] = -1;
          if (stream[k] && last_acc[k] >= 0)
            chk({m_tag, " accept spacing"}, cyc - last_acc[k], m_n + 2);
          last_acc[k] = cyc;
        end else if (pend[k] && elapsed[k] >= m_n && m_or) begin
          pend[k] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic set_in(input bit w16, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic bi);
    if (w16) begin
      if16.in_valid = v; if16.A = a; if16.B = b; if16.bin = bi;
    end else begin
      if8.in_valid = v; if8.A = a[7:0]; if8.B = b[7:0]; if8.bin = bi;
    end
  endtask

  task automatic set_ordy(input bit w16, input logic r);
    if (w16) if16.out_ready = r;
    else     if8.out_ready  = r;
  endtask

  function automatic logic get_ov(input bit w16);
    return w16 ? if16.out_valid : if8.out_valid;
  endfunction

  function automatic logic get_iy(input bit w16);
    return w16 ? if16.in_ready : if8.in_ready;
  endfunction

  // Presents one operand set from IDLE, waits for the result, optionally
  // stalls the consumer for 'hold' clocks, and returns to IDLE.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input int hold, output logic [15:0] d, output logic bo, output logic z,
                        output int lat);
    set_in(w16, 1'b1, a, b, bi);
    set_ordy(w16, hold == 0);
    @(posedge clk); #1;
    set_in(w16, 1'b0, 16'h0, 16'h0, 1'b0);
    lat = 0;
    while (!get_ov(w16) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) begin
      checks++; errors++;
      $display("FAIL op timeout: got no out_valid within %0d clocks", lat);
    end
    d  = w16 ? if16.D : {8'h00, if8.D};
    bo = w16 ? if16.Bout : if8.Bout;
    z  = w16 ? if16.zero : if8.zero;
    for (int i = 0; i < hold; i++) begin
      set_in(w16, 1'b1, 16'h00AA + 16'(i), 16'h0011, 1'b1);
      @(posedge clk); #1;
      chk("stall in_ready", get_iy(w16), 1'b0);
      chk("stall out_valid", get_ov(w16), 1'b1);
    end
    set_in(w16, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ordy(w16, 1'b1);
    @(posedge clk); #1;
    chk("post-handshake in_ready", get_iy(w16), 1'b1);
    chk("post-handshake out_valid", get_ov(w16), 1'b0);
  endtask

  logic [15:0] r_d;
  logic        r_bo, r_z;
  int          r_lat;
  bit          seen;

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ordy(1'b0, 1'b1);
    set_ordy(1'b1, 1'b1);
    #2;
    chk("rst w8 in_ready",   if8.in_ready, 1'b1);
    chk("rst w8 out_valid",  if8.out_valid, 1'b0);
    chk("rst w8 D",          if8.D, 8'h00);
    chk("rst w8 Bout",       if8.Bout, 1'b0);
    chk("rst w8 zero",       if8.zero, 1'b0);
    chk("rst w16 in_ready",  if16.in_ready, 1'b1);
    chk("rst w16 out_valid", if16.out_valid, 1'b0);
    chk("rst w16 D",         if16.D, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic 8-bit subtraction and its latency.
    run_op(1'b0, 16'h5A, 16'h3C, 1'b0, 0, r_d, r_bo, r_z, r_lat);
    chk("t1 latency", r_lat, 2);
    chk("t1 D", r_d, 16'h001E);
    chk("t1 Bout", r_bo, 1'b0);
    chk("t1 zero", r_z, 1'b0);

    // Underflow wraps; borrow-in that lands exactly on zero.
    run_op(1'b0, 16'h00, 16'h01, 1'b0, 0, r_d, r_bo, r_z, r_lat);
    chk("t2a D", r_d, 16'h00FF);
    chk("t2a Bout", r_bo, 1'b1);
    run_op(1'b0, 16'h10, 16'h0F, 1'b1, 0, r_d, r_bo, r_z, r_lat);
    chk("t2b D", r_d, 16'h0000);
    chk("t2b Bout", r_bo, 1'b0);
    chk("t2b zero", r_z, 1'b1);

    // Consumer stall with ignored operands, then the next op is accepted.
    run_op(1'b0, 16'hA5, 16'h5A, 1'b1, 5, r_d, r_bo, r_z, r_lat);
    chk("t3 D", r_d, 16'h004A);
    chk("t3 Bout", r_bo, 1'b0);
    run_op(1'b0, 16'h03, 16'h07, 1'b0, 0, r_d, r_bo, r_z, r_lat);
    chk("t3 next D", r_d, 16'h00FC);
    chk("t3 next Bout", r_bo, 1'b1);

    // Reset part-way through RUN discards the operation.
    set_in(1'b0, 1'b1, 16'hFF, 16'h00, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t4 out_valid", if8.out_valid, 1'b0);
    chk("t4 D", if8.D, 8'h00);
    chk("t4 Bout", if8.Bout, 1'b0);
    chk("t4 zero", if8.zero, 1'b0);
    chk("t4 in_ready", if8.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if8.out_valid) seen = 1;
    end
    chk("t4 no result after reset", seen, 1'b0);

    // 16-bit: four slices.
    run_op(1'b1, 16'h1234, 16'h4321, 1'b0, 0, r_d, r_bo, r_z, r_lat);
    chk("t5 latency", r_lat, 4);
    chk("t5 D", r_d, 16'hCF13);
    chk("t5 Bout", r_bo, 1'b1);
    chk("t5 zero", r_z, 1'b0);

    // Back-to-back streams with in_valid held high and out_ready=1.
    for (int k = 0; k < 2; k++) begin
      stream[k] = 1;
      repeat (150) begin
        set_in(k == 1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      set_in(k == 1, 1'b0, 16'h0, 16'h0, 1'b0);
      stream[k] = 0;
      repeat (8) @(posedge clk);
      #1;
    end

    // Random valid and ready on both DUTs at once.
    repeat (400) begin
      set_in(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
      set_in(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
      set_ordy(1'b0, $urandom_range(0, 3) != 0);
      set_ordy(1'b1, $urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ordy(1'b0, 1'b1);
    set_ordy(1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
